truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
Sequencer and checker for a 4-input, 1-output combinational function unit (inputs a, b, c, d; output f).
- On start, drives all 16 input vectors in ascending order.
- Waits a configurable settle time per vector, samples f, and builds the 16-bit truth table.
- Compares the table bit-by-bit against an expected table latched at start.
- Sits between a lab control/test harness and the function unit; one function unit per sequencer.

Parameters:
SETTLE_CYCLES, 1, idle cycles between driving a vector and sampling f; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
expected  input  16  golden truth table; bit i is the expected f for vector i; latched when start is accepted
f_in  input  1  output f of the function unit
a  output  1  function-unit input, vector index bit 3
b  output  1  function-unit input, vector index bit 2
c  output  1  function-unit input, vector index bit 1
d  output  1  function-unit input, vector index bit 0
busy  output  1  high from start acceptance until the DONE state is entered
done  output  1  one-cycle pulse when the sweep completes
table_out  output  16  captured truth table; bit i = f sampled for vector i
mismatch_count  output  5  number of bits where table_out differs from expected (0..16)
match  output  1  high when the last completed sweep had zero mismatches

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx=0, so a, b, c, d = 0.
  - busy=0, done=0, table_out=16'h0000, mismatch_count=0, match=0.
  - Reset asserted mid-sweep aborts it immediately; no done pulse is produced.
- Vector mapping: {a,b,c,d} = idx[3:0], driven combinationally from the idx register.
- States:
  - IDLE:
    - start=1 at an edge: latch expected, clear table_out, mismatch_count and match, set idx=0, busy=1, go to DRIVE.
  - DRIVE (1 cycle):
    - Vector is stable on a..d.
    - Go to SETTLE if SETTLE_CYCLES>0, otherwise go to SAMPLE.
  - SETTLE (exactly SETTLE_CYCLES cycles):
    - Down-counter; go to SAMPLE when it expires.
  - SAMPLE (1 cycle):
    - table_out[idx] <= f_in.
    - If f_in != expected_q[idx], mismatch_count increments by 1 (saturation is not reachable: maximum is 16).
    - If idx==15: go to DONE, busy=0. Otherwise idx increments and go to DRIVE.
  - DONE (1 cycle):
    - done=1.
    - match <= (mismatch_count==0).
    - Go to IDLE; idx returns to 0.
- Timing: each vector takes SETTLE_CYCLES+2 cycles. done is high in the cycle that begins 16*(SETTLE_CYCLES+2) edges after the edge that accepted start (48 edges for the default).
- start is ignored while busy=1 and in DONE. expected changes after acceptance have no effect.
- table_out, mismatch_count and match hold their values after DONE until the next accepted start.
- All outputs except a..d are registered.

Optional Feature:
Macro: STOP_ON_FAIL_EN
- Defined:
  - The first mismatching SAMPLE goes directly to DONE instead of continuing the sweep.
  - Extra registered output fail_index[3:0] holds the idx of that mismatch; reset value 0; cleared at start.
  - table_out bits above fail_index remain 0.
  - match=0 and mismatch_count=1 after an early stop.
  - A sweep with no mismatches behaves identically to the macro-undefined build.
- Undefined:
  - The sweep always covers all 16 vectors.
  - The fail_index port does not exist.

Decomposition:
- Shared package truth_table_pkg holds:
  - state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE)
  - VEC_COUNT=16
  - IDX_W=4
  - CNT_W=5
- One sub-module is natural: settle_timer, a loadable down-counter with an expire flag, parameterised by SETTLE_CYCLES. All other logic stays in the top FSM.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release -> all outputs 0, a..d=0, state IDLE; assert rst_n=0 mid-sweep at vector 7 -> outputs return to reset values within the same cycle, no done pulse.
2. Full sweep, pass: function unit f=(a&d)|c, SETTLE_CYCLES=1, expected=16'hEECC, pulse start -> a..d step 0..15, each vector held 3 cycles; done after 48 edges; table_out=16'hEECC, mismatch_count=0, match=1.
3. Full sweep, fail: same function unit, expected=16'hEECD -> table_out=16'hEECC, mismatch_count=1, match=0; with STOP_ON_FAIL_EN, done after 3 edges, fail_index=0, table_out=16'h0000.
4. Start while busy: pulse start again at vector 5 with expected changed to 16'h0000 -> ignored; results match scenario 2; exactly one done pulse.
5. SETTLE_CYCLES=0: function unit constant f=1, expected=16'hFFFF -> each vector held 2 cycles; done after 32 edges; table_out=16'hFFFF, match=1.
6. Back-to-back: pulse start in the cycle after done (IDLE) -> new sweep accepted; table_out cleared to 0 on acceptance; match cleared to 0 on acceptance.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the truth-table sequencer and its settle timer.
package truth_table_pkg;
    localparam int VEC_COUNT = 16;
    localparam int IDX_W     = 4;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;
endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable down-counter; expired is high in the last of SETTLE_CYCLES enabled cycles.
module settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == 4'd1);
endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 input vectors of a 4-in/1-out function unit and checks its truth table.
// Optional STOP_ON_FAIL_EN: end the sweep at the first mismatch and report fail_index.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VEC_COUNT-1:0] expected,
    input  logic                 f_in,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 d,
    output logic                 busy,
    output logic                 done,
    output logic [VEC_COUNT-1:0] table_out,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic                 match
`ifdef STOP_ON_FAIL_EN
    ,
    output logic [IDX_W-1:0]     fail_index
`endif
);
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [VEC_COUNT-1:0] expected_q, expected_d;
    logic [VEC_COUNT-1:0] table_q, table_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 match_q, match_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 miss, last, timer_expired;
`ifdef STOP_ON_FAIL_EN
    logic [IDX_W-1:0]     fail_index_q, fail_index_d;
`endif

    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state_q == DRIVE),
        .en      (state_q == SETTLE),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        expected_d = expected_q;
        table_d    = table_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        miss       = 1'b0;
        last       = 1'b0;
`ifdef STOP_ON_FAIL_EN
        fail_index_d = fail_index_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    expected_d = expected;
                    table_d    = '0;
                    cnt_d      = '0;
                    match_d    = 1'b0;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = DRIVE;
`ifdef STOP_ON_FAIL_EN
                    fail_index_d = '0;
`endif
                end
            end
            DRIVE:  state_d = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;
            SETTLE: if (timer_expired) state_d = SAMPLE;
            SAMPLE: begin
                table_d[idx_q] = f_in;
                miss = (f_in != expected_q[idx_q]);
                if (miss) cnt_d = cnt_q + 5'd1;
                last = (idx_q == IDX_W'(VEC_COUNT - 1));
`ifdef STOP_ON_FAIL_EN
                if (miss) begin
                    last         = 1'b1;
                    fail_index_d = idx_q;
                end
`endif
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                match_d = (cnt_q == '0);
                idx_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            expected_q <= '0;
            table_q    <= '0;
            cnt_q      <= '0;
            match_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef STOP_ON_FAIL_EN
            fail_index_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            expected_q <= expected_d;
            table_q    <= table_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef STOP_ON_FAIL_EN
            fail_index_q <= fail_index_d;
`endif
        end
    end

    assign {a, b, c, d}   = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign table_out      = table_q;
    assign mismatch_count = cnt_q;
    assign match          = match_q;
`ifdef STOP_ON_FAIL_EN
    assign fail_index     = fail_index_q;
`endif
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE_CYCLES=1 and 0) driving modelled function units.
module tb_truth_table_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start1 = 1'b0, start0 = 1'b0;
    logic [15:0] exp1 = '0, exp0 = '0;
    logic fs1 = 1'b0, fs0 = 1'b1;
    logic a1, b1, c1, d1, busy1, done1, match1;
    logic a0, b0, c0, d0, busy0, done0, match0;
    logic [15:0] tbl1, tbl0;
    logic [4:0] cnt1, cnt0;
`ifdef STOP_ON_FAIL_EN
    logic [3:0] fi1, fi0;
`endif

    // Function unit under test: f = (a&d)|c, or constant 1 when fs is set.
    wire f1 = fs1 ? 1'b1 : ((a1 & d1) | c1);
    wire f0 = fs0 ? 1'b1 : ((a0 & d0) | c0);

    truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .f_in(f1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(tbl1), .mismatch_count(cnt1), .match(match1)
`ifdef STOP_ON_FAIL_EN
        , .fail_index(fi1)
`endif
    );

    truth_table_sequencer #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .f_in(f0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
        .table_out(tbl0), .mismatch_count(cnt0), .match(match0)
`ifdef STOP_ON_FAIL_EN
        , .fail_index(fi0)
`endif
    );

    typedef struct {
        logic [15:0] exp;
        logic        fs;
        bit          restart;
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic        mt;
        int          edges;
        logic [3:0]  fidx;
    } vec_t;

    vec_t tv[6];
    vec_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic chk_idle1(input string nm);
        chk({nm, "_vec"}, 32'({a1, b1, c1, d1}), 0);
        chk({nm, "_busy"}, 32'(busy1), 0);
        chk({nm, "_done"}, 32'(done1), 0);
        chk({nm, "_tbl"}, 32'(tbl1), 0);
        chk({nm, "_cnt"}, 32'(cnt1), 0);
        chk({nm, "_match"}, 32'(match1), 0);
    endtask

    // One sweep on dut1; starts at a negedge and returns at a negedge with the DUT in IDLE.
    task automatic sweep1(input vec_t v);
        vec_t e;
        bit seen = 0;
        int j;
        int nd = 0;
        start1 = 1'b1; exp1 = v.exp; fs1 = v.fs;
        sb.push_back(v);
        @(negedge clk);
        start1 = 1'b0;
        exp1 = 16'($urandom);
        for (j = 0; j < 200; j++) begin
            start1 = 1'b0;
            if (j == 0) begin
                chk("clr_table", 32'(tbl1), 0);
                chk("clr_match", 32'(match1), 0);
                chk("clr_cnt", 32'(cnt1), 0);
                chk("busy_on", 32'(busy1), 1);
            end
            if (done1) begin
                seen = 1;
                break;
            end
            if (j < 48) chk("vector", 32'({a1, b1, c1, d1}), 32'(j / 3));
            if (v.restart && j == 15) begin
                start1 = 1'b1;
                exp1 = 16'h0000;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(seen), 1);
        if (seen) begin
            e = sb.pop_front();
            chk("done_edge", 32'(j), 32'(e.edges));
            chk("table_out", 32'(tbl1), 32'(e.tbl));
            chk("mismatch_count", 32'(cnt1), 32'(e.cnt));
            chk("busy_off", 32'(busy1), 0);
`ifdef STOP_ON_FAIL_EN
            chk("fail_index", 32'(fi1), 32'(e.fidx));
`endif
            @(negedge clk);
            chk("match", 32'(match1), 32'(e.mt));
            chk("done_pulse", 32'(done1), 0);
            chk("idx_back", 32'({a1, b1, c1, d1}), 0);
            chk("table_hold", 32'(tbl1), 32'(e.tbl));
        end
        if (v.restart) begin
            repeat (60) begin
                @(negedge clk);
                if (done1) nd++;
            end
            chk("single_done", 32'(nd), 0);
            chk("table_held", 32'(tbl1), 32'(v.tbl));
        end
    endtask

    initial begin
        int j;
        bit seen;
        int nd;
        //         exp       fs   rst  tbl       cnt  mt  edges fidx
        tv[0] = '{16'hEECC, 1'b0, 0, 16'hEECC, 5'd0,  1, 48, 4'd0};
`ifdef STOP_ON_FAIL_EN
        tv[1] = '{16'hEECD, 1'b0, 0, 16'h0000, 5'd1,  0, 3,  4'd0};
`else
        tv[1] = '{16'hEECD, 1'b0, 0, 16'hEECC, 5'd1,  0, 48, 4'd0};
`endif
        tv[2] = '{16'hEECC, 1'b0, 1, 16'hEECC, 5'd0,  1, 48, 4'd0};
        tv[3] = '{16'hFFFF, 1'b1, 0, 16'hFFFF, 5'd0,  1, 48, 4'd0};
`ifdef STOP_ON_FAIL_EN
        tv[4] = '{16'h0000, 1'b0, 0, 16'h0004, 5'd1,  0, 9,  4'd2};
        tv[5] = '{16'h0000, 1'b1, 0, 16'h0001, 5'd1,  0, 3,  4'd0};
`else
        tv[4] = '{16'h0000, 1'b0, 0, 16'hEECC, 5'd10, 0, 48, 4'd0};
        tv[5] = '{16'h0000, 1'b1, 0, 16'hFFFF, 5'd16, 0, 48, 4'd0};
`endif

        // Reset held for 3 cycles, then released.
        repeat (3) @(negedge clk);
        chk_idle1("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle1("post_reset");

        // Reset asserted while vector 7 is on the pins.
        start1 = 1'b1; exp1 = 16'hEECC; fs1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        repeat (21) @(negedge clk);
        chk("pre_rst_vec", 32'({a1, b1, c1, d1}), 7);
        chk("pre_rst_tbl", 32'(tbl1), 32'h004C);
        #1 rst_n = 1'b0;
        #1 chk_idle1("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (60) begin
            @(negedge clk);
            if (done1) nd++;
        end
        chk("abort_no_done", 32'(nd), 0);
        chk_idle1("after_abort");

        // Table-driven sweeps, issued back-to-back (start in the IDLE cycle after done).
        for (int i = 0; i < 6; i++) sweep1(tv[i]);

        // Zero settle time: each vector held 2 cycles, done after 32 edges.
        start0 = 1'b1; exp0 = 16'hFFFF; fs0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        seen = 0;
        for (j = 0; j < 200; j++) begin
            if (done0) begin
                seen = 1;
                break;
            end
            if (j < 32) chk("vector0", 32'({a0, b0, c0, d0}), 32'(j / 2));
            @(negedge clk);
        end
        chk("done0_seen", 32'(seen), 1);
        chk("done0_edge", 32'(j), 32);
        chk("table0", 32'(tbl0), 32'hFFFF);
        chk("cnt0", 32'(cnt0), 0);
        @(negedge clk);
        chk("match0", 32'(match0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
